// File: rtl/res_station.sv
// res_station: reservation station holding renamed instructions until both
// source operands are available, snooping two result buses, and issuing the
// oldest ready entry to its functional unit over a valid/ready handshake.
module res_station #(
  parameter int         DEPTH = 8,
  parameter logic [1:0] RESID = 2'd0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         wr1_en,
  input  logic [1:0]                   wr1_resnum,
  input  logic [3:0]                   wr1_fuctl,
  input  logic [31:0]                  wr1_imm,
  input  logic [31:0]                  wr1_bpc,
  input  logic                         wr1_rd_en,
  input  logic [5:0]                   wr1_rdp,
  input  logic [31:0]                  wr1_rs_data,
  input  logic [31:0]                  wr1_rt_data,
  input  logic                         wr1_rs_v,
  input  logic                         wr1_rt_v,
  input  logic                         wr2_en,
  input  logic [1:0]                   wr2_resnum,
  input  logic [3:0]                   wr2_fuctl,
  input  logic [31:0]                  wr2_imm,
  input  logic [31:0]                  wr2_bpc,
  input  logic                         wr2_rd_en,
  input  logic [5:0]                   wr2_rdp,
  input  logic [31:0]                  wr2_rs_data,
  input  logic [31:0]                  wr2_rt_data,
  input  logic                         wr2_rs_v,
  input  logic                         wr2_rt_v,
  input  logic                         cdb0_en,
  input  logic [5:0]                   cdb0_tag,
  input  logic [31:0]                  cdb0_data,
  input  logic                         cdb1_en,
  input  logic [5:0]                   cdb1_tag,
  input  logic [31:0]                  cdb1_data,
  input  logic                         iss_ready,
  output logic                         iss_valid,
  output logic [3:0]                   iss_fuctl,
  output logic [31:0]                  iss_imm,
  output logic [31:0]                  iss_bpc,
  output logic                         iss_rd_en,
  output logic [5:0]                   iss_rdp,
  output logic [31:0]                  iss_rs,
  output logic [31:0]                  iss_rt,
  output logic                         stall,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [3:0]  fuctl;
    logic [31:0] imm;
    logic [31:0] bpc;
    logic        rd_en;
    logic [5:0]  rdp;
    logic [31:0] rs;
    logic        rs_v;
    logic [31:0] rt;
    logic        rt_v;
  } entry_t;

  // An operand that is still waiting carries its physical tag in the low
  // six bits; CDB0 takes precedence if both buses claim the same tag.
  function automatic entry_t applyCdb(
    input entry_t      e,
    input logic        c0En,
    input logic [5:0]  c0Tag,
    input logic [31:0] c0Data,
    input logic        c1En,
    input logic [5:0]  c1Tag,
    input logic [31:0] c1Data
  );
    entry_t r;
    r = e;
    if (!e.rs_v) begin
      if (c0En && (c0Tag == e.rs[5:0])) begin
        r.rs   = c0Data;
        r.rs_v = 1'b1;
      end else if (c1En && (c1Tag == e.rs[5:0])) begin
        r.rs   = c1Data;
        r.rs_v = 1'b1;
      end
    end
    if (!e.rt_v) begin
      if (c0En && (c0Tag == e.rt[5:0])) begin
        r.rt   = c0Data;
        r.rt_v = 1'b1;
      end else if (c1En && (c1Tag == e.rt[5:0])) begin
        r.rt   = c1Data;
        r.rt_v = 1'b1;
      end
    end
    return r;
  endfunction

  entry_t          ent_q [DEPTH];
  entry_t          ent_d [DEPTH];
  entry_t          woken [DEPTH+1];
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  entry_t          inEnt1;
  entry_t          inEnt2;
  logic            acc1;
  logic            acc2;
  logic [DEPTH-1:0] ready;
  logic            found;
  int              selIdx;
  entry_t          pick;
  logic            issue;
  int              occ;
  int              tail;

  assign occ   = int'(count_q);
  assign stall = (DEPTH - occ) < 2;
  assign count = count_q;

  // Capture incoming instructions, bypassing any operand broadcast this cycle
  always_comb begin
    inEnt1 = '{fuctl: wr1_fuctl, imm: wr1_imm, bpc: wr1_bpc, rd_en: wr1_rd_en,
               rdp: wr1_rdp, rs: wr1_rs_data, rs_v: wr1_rs_v,
               rt: wr1_rt_data, rt_v: wr1_rt_v};
    inEnt2 = '{fuctl: wr2_fuctl, imm: wr2_imm, bpc: wr2_bpc, rd_en: wr2_rd_en,
               rdp: wr2_rdp, rs: wr2_rs_data, rs_v: wr2_rs_v,
               rt: wr2_rt_data, rt_v: wr2_rt_v};
    inEnt1 = applyCdb(inEnt1, cdb0_en, cdb0_tag, cdb0_data, cdb1_en, cdb1_tag, cdb1_data);
    inEnt2 = applyCdb(inEnt2, cdb0_en, cdb0_tag, cdb0_data, cdb1_en, cdb1_tag, cdb1_data);
    acc1   = wr1_en && (wr1_resnum == RESID) && !stall;
    acc2   = wr2_en && (wr2_resnum == RESID) && !stall;
  end

  // An entry is ready only from registered operand state, never this cycle's CDB
  always_comb begin
    ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = (i < occ) && ent_q[i].rs_v && ent_q[i].rt_v;
    end
  end

  // Pick the oldest ready entry; payload is forced to zero when nothing is ready
  always_comb begin
    found  = 1'b0;
    selIdx = 0;
    pick   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && !found) begin
        found  = 1'b1;
        selIdx = i;
        pick   = ent_q[i];
      end
    end
  end

  assign iss_valid = found;
  assign issue     = found && iss_ready;
  assign iss_fuctl = pick.fuctl;
  assign iss_imm   = pick.imm;
  assign iss_bpc   = pick.bpc;
  assign iss_rd_en = pick.rd_en;
  assign iss_rdp   = pick.rdp;
  assign iss_rs    = pick.rs;
  assign iss_rt    = pick.rt;

  // Wake stored operands, close the gap left by an issue, then append new writes
  always_comb begin
    tail = occ - int'(issue);
    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = applyCdb(ent_q[i], cdb0_en, cdb0_tag, cdb0_data, cdb1_en, cdb1_tag, cdb1_data);
    end
    woken[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (issue && (i >= selIdx)) begin
        ent_d[i] = woken[i+1];
      end else begin
        ent_d[i] = woken[i];
      end
      if (acc1 && (i == tail)) begin
        ent_d[i] = inEnt1;
      end
      if (acc2 && (i == tail + int'(acc1))) begin
        ent_d[i] = inEnt2;
      end
    end
    count_d = CW'(occ + int'(acc1) + int'(acc2) - int'(issue));
  end

  // Queue state register; reset and flush both empty the station
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

endmodule

// File: tb/tb_res_station.sv
// tb_res_station: directed scenarios plus randomized traffic, each cycle
// compared against a queue-based reference of the reservation station.
`timescale 1ns/1ps
module tb_res_station;

  localparam int         DEPTH = 8;
  localparam logic [1:0] RESID = 2'd0;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        wr1_en, wr1_rd_en, wr1_rs_v, wr1_rt_v;
  logic [1:0]  wr1_resnum;
  logic [3:0]  wr1_fuctl;
  logic [5:0]  wr1_rdp;
  logic [31:0] wr1_imm, wr1_bpc, wr1_rs_data, wr1_rt_data;
  logic        wr2_en, wr2_rd_en, wr2_rs_v, wr2_rt_v;
  logic [1:0]  wr2_resnum;
  logic [3:0]  wr2_fuctl;
  logic [5:0]  wr2_rdp;
  logic [31:0] wr2_imm, wr2_bpc, wr2_rs_data, wr2_rt_data;
  logic        cdb0_en, cdb1_en;
  logic [5:0]  cdb0_tag, cdb1_tag;
  logic [31:0] cdb0_data, cdb1_data;
  logic        iss_ready, iss_valid, iss_rd_en, stall;
  logic [3:0]  iss_fuctl;
  logic [5:0]  iss_rdp;
  logic [31:0] iss_imm, iss_bpc, iss_rs, iss_rt;
  logic [$clog2(DEPTH+1)-1:0] count;

  // Free-running 10ns clock
  always #5 clk = ~clk;

  res_station #(.DEPTH(DEPTH), .RESID(RESID)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr1_en(wr1_en), .wr1_resnum(wr1_resnum), .wr1_fuctl(wr1_fuctl), .wr1_imm(wr1_imm),
    .wr1_bpc(wr1_bpc), .wr1_rd_en(wr1_rd_en), .wr1_rdp(wr1_rdp),
    .wr1_rs_data(wr1_rs_data), .wr1_rt_data(wr1_rt_data), .wr1_rs_v(wr1_rs_v), .wr1_rt_v(wr1_rt_v),
    .wr2_en(wr2_en), .wr2_resnum(wr2_resnum), .wr2_fuctl(wr2_fuctl), .wr2_imm(wr2_imm),
    .wr2_bpc(wr2_bpc), .wr2_rd_en(wr2_rd_en), .wr2_rdp(wr2_rdp),
    .wr2_rs_data(wr2_rs_data), .wr2_rt_data(wr2_rt_data), .wr2_rs_v(wr2_rs_v), .wr2_rt_v(wr2_rt_v),
    .cdb0_en(cdb0_en), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
    .cdb1_en(cdb1_en), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
    .iss_ready(iss_ready), .iss_valid(iss_valid), .iss_fuctl(iss_fuctl), .iss_imm(iss_imm),
    .iss_bpc(iss_bpc), .iss_rd_en(iss_rd_en), .iss_rdp(iss_rdp), .iss_rs(iss_rs), .iss_rt(iss_rt),
    .stall(stall), .count(count)
  );

  typedef struct {
    logic [3:0]  fuctl;
    logic [31:0] imm;
    logic [31:0] bpc;
    logic        rdEn;
    logic [5:0]  rdp;
    logic [31:0] rs;
    logic        rsV;
    logic [31:0] rt;
    logic        rtV;
  } ModelEntry;

  ModelEntry modelQ[$];
  int checkCount = 0;
  int passCount  = 0;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Resolve one waiting operand against this cycle's broadcasts
  function automatic logic [32:0] resolve(input logic [31:0] val, input logic v);
    if (v) return {1'b1, val};
    if (cdb0_en && cdb0_tag == val[5:0]) return {1'b1, cdb0_data};
    if (cdb1_en && cdb1_tag == val[5:0]) return {1'b1, cdb1_data};
    return {1'b0, val};
  endfunction

  function automatic ModelEntry snoopEntry(input ModelEntry e);
    ModelEntry r;
    r = e;
    {r.rsV, r.rs} = resolve(e.rs, e.rsV);
    {r.rtV, r.rt} = resolve(e.rt, e.rtV);
    return r;
  endfunction

  function automatic ModelEntry incoming(input int which);
    ModelEntry e;
    if (which == 1)
      e = '{fuctl: wr1_fuctl, imm: wr1_imm, bpc: wr1_bpc, rdEn: wr1_rd_en, rdp: wr1_rdp,
            rs: wr1_rs_data, rsV: wr1_rs_v, rt: wr1_rt_data, rtV: wr1_rt_v};
    else
      e = '{fuctl: wr2_fuctl, imm: wr2_imm, bpc: wr2_bpc, rdEn: wr2_rd_en, rdp: wr2_rdp,
            rs: wr2_rs_data, rsV: wr2_rs_v, rt: wr2_rt_data, rtV: wr2_rt_v};
    return snoopEntry(e);
  endfunction

  // Compare outputs mid-cycle against the model, advance the model, cross the edge
  task automatic stepCycle();
    ModelEntry exp;
    int        n, sel;
    bit        expValid, expStall, acc1, acc2, issue;
    @(negedge clk);
    n   = modelQ.size();
    sel = -1;
    for (int i = 0; i < n; i++)
      if (sel < 0 && modelQ[i].rsV && modelQ[i].rtV) sel = i;
    expValid = (sel >= 0);
    expStall = (DEPTH - n) < 2;
    exp = '{fuctl: 0, imm: 0, bpc: 0, rdEn: 0, rdp: 0, rs: 0, rsV: 0, rt: 0, rtV: 0};
    if (expValid) exp = modelQ[sel];
    checkOutput("count", count, n);
    checkOutput("stall", stall, expStall);
    checkOutput("iss_valid", iss_valid, expValid);
    checkOutput("iss_fuctl", iss_fuctl, exp.fuctl);
    checkOutput("iss_imm", iss_imm, exp.imm);
    checkOutput("iss_bpc", iss_bpc, exp.bpc);
    checkOutput("iss_rd_en", iss_rd_en, exp.rdEn);
    checkOutput("iss_rdp", iss_rdp, exp.rdp);
    checkOutput("iss_rs", iss_rs, exp.rs);
    checkOutput("iss_rt", iss_rt, exp.rt);
    acc1  = wr1_en && (wr1_resnum == RESID) && !expStall;
    acc2  = wr2_en && (wr2_resnum == RESID) && !expStall;
    issue = expValid && iss_ready;
    if (rst || flush) begin
      modelQ.delete();
    end else begin
      foreach (modelQ[i]) modelQ[i] = snoopEntry(modelQ[i]);
      if (issue) modelQ.delete(sel);
      if (acc1) modelQ.push_back(incoming(1));
      if (acc2) modelQ.push_back(incoming(2));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    rst = 0; flush = 0; iss_ready = 0;
    wr1_en = 0; wr1_resnum = 0; wr1_fuctl = 0; wr1_imm = 0; wr1_bpc = 0; wr1_rd_en = 0;
    wr1_rdp = 0; wr1_rs_data = 0; wr1_rt_data = 0; wr1_rs_v = 0; wr1_rt_v = 0;
    wr2_en = 0; wr2_resnum = 0; wr2_fuctl = 0; wr2_imm = 0; wr2_bpc = 0; wr2_rd_en = 0;
    wr2_rdp = 0; wr2_rs_data = 0; wr2_rt_data = 0; wr2_rs_v = 0; wr2_rt_v = 0;
    cdb0_en = 0; cdb0_tag = 0; cdb0_data = 0;
    cdb1_en = 0; cdb1_tag = 0; cdb1_data = 0;
  endtask

  // Present one directed instruction on write port 1 or 2
  task automatic setWr(input int which, input logic [31:0] rs, input logic rsV,
                       input logic [31:0] rt, input logic rtV, input logic [3:0] fuctl);
    if (which == 1) begin
      wr1_en = 1; wr1_resnum = RESID; wr1_fuctl = fuctl; wr1_imm = rs + 32'h100;
      wr1_bpc = 32'h4000 + {28'b0, fuctl}; wr1_rd_en = 1; wr1_rdp = {2'b0, fuctl};
      wr1_rs_data = rs; wr1_rs_v = rsV; wr1_rt_data = rt; wr1_rt_v = rtV;
    end else begin
      wr2_en = 1; wr2_resnum = RESID; wr2_fuctl = fuctl; wr2_imm = rs + 32'h200;
      wr2_bpc = 32'h8000 + {28'b0, fuctl}; wr2_rd_en = 1; wr2_rdp = {2'b1, fuctl};
      wr2_rs_data = rs; wr2_rs_v = rsV; wr2_rt_data = rt; wr2_rt_v = rtV;
    end
  endtask

  task automatic randOperand(output logic [31:0] d, output logic v);
    v = 1'($urandom_range(0, 1));
    d = v ? $urandom : {26'b0, 6'($urandom_range(0, 7))};
  endtask

  // Randomized traffic with a small tag space so wakeups and bypasses are frequent
  task automatic applyStimulus();
    rst   = ($urandom_range(0, 199) == 0);
    flush = ($urandom_range(0, 49) == 0);
    iss_ready  = ($urandom_range(0, 9) < 6);
    wr1_en     = ($urandom_range(0, 9) < 6);
    wr1_resnum = ($urandom_range(0, 9) < 7) ? RESID : 2'($urandom_range(0, 3));
    wr1_fuctl  = 4'($urandom); wr1_imm = $urandom; wr1_bpc = $urandom;
    wr1_rd_en  = 1'($urandom); wr1_rdp = 6'($urandom);
    randOperand(wr1_rs_data, wr1_rs_v);
    randOperand(wr1_rt_data, wr1_rt_v);
    wr2_en     = ($urandom_range(0, 9) < 6);
    wr2_resnum = ($urandom_range(0, 9) < 7) ? RESID : 2'($urandom_range(0, 3));
    wr2_fuctl  = 4'($urandom); wr2_imm = $urandom; wr2_bpc = $urandom;
    wr2_rd_en  = 1'($urandom); wr2_rdp = 6'($urandom);
    randOperand(wr2_rs_data, wr2_rs_v);
    randOperand(wr2_rt_data, wr2_rt_v);
    cdb0_en = ($urandom_range(0, 99) < 35); cdb0_tag = 6'($urandom_range(0, 7)); cdb0_data = $urandom;
    cdb1_en = ($urandom_range(0, 99) < 35); cdb1_tag = 6'($urandom_range(0, 7)); cdb1_data = $urandom;
  endtask

  initial begin
    clearInputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    modelQ.delete();
    stepCycle();
    rst = 0;
    checkOutput("reset count", count, 0);
    checkOutput("reset iss_valid", iss_valid, 0);
    checkOutput("reset stall", stall, 0);

    // Single ready instruction: offered the next cycle, then drained
    clearInputs(); setWr(1, 32'd5, 1, 32'd7, 1, 4'd3); iss_ready = 1; stepCycle();
    checkOutput("t1 iss_valid", iss_valid, 1);
    checkOutput("t1 iss_rs", iss_rs, 5);
    checkOutput("t1 iss_rt", iss_rt, 7);
    checkOutput("t1 iss_fuctl", iss_fuctl, 3);
    clearInputs(); iss_ready = 1; stepCycle();
    checkOutput("t1 drained", count, 0);

    // Waiting operand woken by CDB1 two cycles later
    clearInputs(); setWr(1, 32'd12, 0, 32'd9, 1, 4'd1); stepCycle();
    clearInputs(); stepCycle(); stepCycle();
    checkOutput("t2 waiting", iss_valid, 0);
    cdb1_en = 1; cdb1_tag = 6'd12; cdb1_data = 32'hDEADBEEF; stepCycle();
    checkOutput("t2 woken valid", iss_valid, 1);
    checkOutput("t2 woken rs", iss_rs, 32'hDEADBEEF);
    clearInputs(); iss_ready = 1; stepCycle();
    checkOutput("t2 drained", count, 0);

    // Two writes in one cycle keep program order
    clearInputs(); setWr(1, 32'h11, 1, 32'h1, 1, 4'd4); setWr(2, 32'h22, 1, 32'h2, 1, 4'd5);
    iss_ready = 1; stepCycle();
    checkOutput("t3 first", iss_rs, 32'h11);
    clearInputs(); iss_ready = 1; stepCycle();
    checkOutput("t3 second", iss_rs, 32'h22);
    stepCycle();
    checkOutput("t3 drained", count, 0);

    // Younger ready entry overtakes; oldest wins once both become ready
    clearInputs(); setWr(1, 32'd20, 0, 32'h3, 1, 4'd6); setWr(2, 32'h1, 1, 32'h4, 1, 4'd7); stepCycle();
    clearInputs(); setWr(1, 32'd21, 0, 32'h5, 1, 4'd8); stepCycle();
    clearInputs();
    checkOutput("t4 younger offered", iss_rs, 32'h1);
    iss_ready = 1; stepCycle();
    clearInputs(); cdb0_en = 1; cdb0_tag = 6'd20; cdb0_data = 32'hA0A0A0A0;
    cdb1_en = 1; cdb1_tag = 6'd21; cdb1_data = 32'hB0B0B0B0; stepCycle();
    clearInputs();
    checkOutput("t4 oldest first", iss_rs, 32'hA0A0A0A0);
    iss_ready = 1; stepCycle();
    checkOutput("t4 then next", iss_rs, 32'hB0B0B0B0);
    stepCycle();
    checkOutput("t4 drained", count, 0);

    // Fill to DEPTH-1, writes ignored while stalled, issue releases stall at the edge
    for (int k = 0; k < (DEPTH - 2) / 2; k++) begin
      clearInputs(); setWr(1, 32'h100 + k, 1, 0, 1, 4'd1); setWr(2, 32'h200 + k, 1, 0, 1, 4'd2); stepCycle();
    end
    clearInputs(); setWr(1, 32'h300, 1, 0, 1, 4'd3); stepCycle();
    checkOutput("t5 full stall", stall, 1);
    clearInputs(); setWr(1, 32'h400, 1, 0, 1, 4'd4); setWr(2, 32'h500, 1, 0, 1, 4'd5); stepCycle();
    checkOutput("t5 ignored count", count, DEPTH - 1);
    clearInputs(); iss_ready = 1; stepCycle();
    checkOutput("t5 stall released", stall, 0);
    clearInputs(); iss_ready = 1; setWr(1, 32'h600, 1, 0, 1, 4'd6); setWr(2, 32'h700, 1, 0, 1, 4'd7); stepCycle();
    checkOutput("t5 issue plus two", count, DEPTH - 1);
    clearInputs(); iss_ready = 1;
    repeat (DEPTH + 2) stepCycle();
    checkOutput("t5 drained", count, 0);

    // Flush with four entries and concurrent writes, then write-time bypass
    clearInputs(); setWr(1, 32'h10, 1, 0, 1, 4'd1); setWr(2, 32'h20, 1, 0, 1, 4'd2); stepCycle();
    clearInputs(); setWr(1, 32'h30, 1, 0, 1, 4'd3); setWr(2, 32'h40, 1, 0, 1, 4'd4); stepCycle();
    clearInputs(); flush = 1; iss_ready = 1; setWr(1, 32'h50, 1, 0, 1, 4'd5); setWr(2, 32'h60, 1, 0, 1, 4'd6);
    cdb0_en = 1; cdb0_tag = 6'd1; cdb0_data = 32'h77; stepCycle();
    checkOutput("t6 flush count", count, 0);
    checkOutput("t6 flush iss_valid", iss_valid, 0);
    clearInputs(); setWr(1, 32'd30, 0, 32'h44, 1, 4'd9); setWr(2, 32'h55, 1, 32'd31, 0, 4'd10);
    cdb0_en = 1; cdb0_tag = 6'd30; cdb0_data = 32'hCAFEF00D;
    cdb1_en = 1; cdb1_tag = 6'd31; cdb1_data = 32'h00005151; stepCycle();
    clearInputs();
    checkOutput("t6 bypass valid", iss_valid, 1);
    checkOutput("t6 bypass rs", iss_rs, 32'hCAFEF00D);
    iss_ready = 1; stepCycle();
    checkOutput("t6 bypass rt", iss_rt, 32'h00005151);
    stepCycle();

    // Randomized traffic including occasional flush and reset
    for (int c = 0; c < 1500; c++) begin
      applyStimulus();
      stepCycle();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/res_station.md
# res_station

Reservation station downstream of the read-register stage. Captures up to two renamed instructions per cycle whose station number matches `RESID`. Holds them until both source operands are available, snooping two result broadcast buses for missing operands. Issues the oldest ready entry to its functional unit over a valid/ready handshake.

## Interface
- `DEPTH`, 8: number of entries (≥2).
- `RESID`, 2'd0: station number this instance answers to.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: discard all entries (mispredict/exception).
- `wr1_en` in 1: instruction 1 valid and bound for a station (`valid1 & res_en1`).
- `wr1_resnum` in 2: target station of instruction 1.
- `wr1_fuctl` in 4: FU control.
- `wr1_imm` in 32: immediate.
- `wr1_bpc` in 32: instruction PC.
- `wr1_rd_en` in 1: destination write enable.
- `wr1_rdp` in 6: destination physical tag.
- `wr1_rs_data`, `wr1_rt_data` in 32 each: operand value, or `{26'b0,tag}` when not valid.
- `wr1_rs_v`, `wr1_rt_v` in 1 each: operand valid.
- `wr2_*` in: same set for instruction 2.
- `cdb0_en`, `cdb1_en` in 1: result broadcast valid.
- `cdb0_tag`, `cdb1_tag` in 6: broadcast physical tag.
- `cdb0_data`, `cdb1_data` in 32: broadcast value.
- `iss_ready` in 1: FU can accept.
- `iss_valid` out 1: an entry is being offered.
- `iss_fuctl` out 4, `iss_imm` out 32, `iss_bpc` out 32, `iss_rd_en` out 1, `iss_rdp` out 6, `iss_rs` out 32, `iss_rt` out 32: payload of the offered entry.
- `stall` out 1: fewer than 2 free entries; upstream must hold.
- `count` out $clog2(DEPTH+1): occupied entries.

## Operation
- Storage is a compacting queue. Entry 0 is always the oldest. Valid entries are contiguous from 0.
- Accept: `wrN_en & (wrN_resnum==RESID) & ~stall`. Writes presented while `stall`=1 are ignored.
- Both accepted: instruction 1 takes the lower (older) slot, instruction 2 the next.
- Operand tag is `data[5:0]` when its valid bit is 0.
- Wakeup: each cycle, every stored invalid operand compares its tag to each enabled CDB. On match it loads `cdbN_data` and sets valid at the edge. If both CDBs match, CDB0 wins (only occurs on broken upstream).
- Write-time bypass: an incoming invalid operand matching an enabled CDB in the same cycle is stored already valid with the CDB data.
- Ready: entry valid with both operand valid bits set, using registered state only. An entry woken at edge E is issuable from cycle E+1.
- Select: lowest-index ready entry. `iss_*` are combinational from that entry. All `iss_*` are 0 when `iss_valid`=0.
- Issue: on `iss_valid & iss_ready` the selected entry is removed. Younger entries shift down one slot. New writes append after the post-shift tail.
- The selection may change while `iss_ready`=0, e.g. when an older entry becomes ready. The FU samples only on the handshake.
- `stall` = (DEPTH − count) < 2, from registered `count`.
- `count` next value = count + accepted writes − issue.
- Flush: at the edge all entries are invalidated and `count` is set to 0. Flush has priority over simultaneous writes, wakeups and issue. An issue handshake in the flush cycle still counts as transferred.

## Timing
- Reset: all entries invalid, `count`=0, `stall`=0 (DEPTH≥2), `iss_valid`=0, all `iss_*`=0. Reset behaves identically mid-operation and has priority over `flush`.
- Minimum latency is 1 cycle. An instruction written ready at edge E is offered in cycle E+1.
- Wakeup-to-issue is 1 cycle after the CDB cycle.
- Full: with count=DEPTH−1 or DEPTH, `stall`=1. An issue in that cycle lowers `stall` at the next edge, never combinationally.
- Simultaneous issue and two writes with count=DEPTH−2 are legal; the resulting count is DEPTH−1.
- Empty: `iss_valid`=0. A ready write at edge E gives `iss_valid`=1 in cycle E+1.

## Test plan
- Reset, then write instr1 (resnum=RESID, rs_v=rt_v=1, rs=5, rt=7, fuctl=3) -> next cycle `iss_valid`=1, `iss_rs`=5, `iss_rt`=7, `iss_fuctl`=3; with `iss_ready`=1, `count` returns to 0.
- Write an entry with rs invalid, tag 6'd12; after two cycles drive `cdb1_en`=1, tag 12, data 0xDEADBEEF -> `iss_valid` rises the cycle after the CDB cycle, with `iss_rs`=0xDEADBEEF.
- Write two instructions in one cycle, both ready, with `iss_ready`=1 -> instr1 issues first, instr2 on the following cycle; order is preserved.
- Entry 0 waiting, entry 1 ready -> entry 1 issues. Entries 0 and 2 then become ready together -> entry 0 issues first.
- Fill to DEPTH−1 -> `stall`=1 and further writes are ignored (`count` unchanged). One issue -> `stall`=0 the next cycle.
- Assert `flush` with 4 entries and concurrent writes -> next cycle `count`=0, `iss_valid`=0. Incoming write with CDB tag match in the same cycle is stored valid (bypass).
